// File: rtl/axi4l_pkg.sv
// Shared AXI4-Lite definitions for the basic master/slave pair:
// FSM state encoding, response codes, PROT default and bus width defaults.
package axi4l_pkg;

   localparam int AXI_ADDR_WIDTH = 2;
   localparam int AXI_DATA_WIDTH = 8;

   localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_REQ  = 3'd1,
      WR_RESP = 3'd2,
      RD_REQ  = 3'd3,
      RD_DATA = 3'd4,
      RESPOND = 3'd5
   } state_t;

endpackage

// File: rtl/basic_axi4_lite_master.sv
// Single-outstanding AXI4-Lite master: turns a valid/ready command into one
// AXI4-Lite read or write and returns the data/response on a valid/ready port.
module basic_axi4_lite_master
   import axi4l_pkg::*;
#(
   parameter int         ADDR_WIDTH = AXI_ADDR_WIDTH,
   parameter int         DATA_WIDTH = AXI_DATA_WIDTH,
   parameter int         STRB_WIDTH = ((DATA_WIDTH / 8) < 1) ? 1 : (DATA_WIDTH / 8),
   parameter logic [2:0] PROT_VALUE = AXI_PROT_DEFAULT
) (
   input  logic                  i_ACLK,
   input  logic                  i_ARESETN,
   input  logic                  i_CMD_VALID,
   output logic                  o_CMD_READY,
   input  logic                  i_CMD_WRITE,
   input  logic [ADDR_WIDTH-1:0] i_CMD_ADDR,
   input  logic [DATA_WIDTH-1:0] i_CMD_WDATA,
   input  logic [STRB_WIDTH-1:0] i_CMD_WSTRB,
   output logic                  o_RSP_VALID,
   input  logic                  i_RSP_READY,
   output logic [DATA_WIDTH-1:0] o_RSP_RDATA,
   output logic [1:0]            o_RSP_RESP,
   output logic                  o_RSP_WRITE,
   output logic                  o_M_AWVALID,
   output logic [ADDR_WIDTH-1:0] o_M_AWADDR,
   output logic [2:0]            o_M_AWPROT,
   input  logic                  i_S_AWREADY,
   output logic                  o_M_WVALID,
   output logic [DATA_WIDTH-1:0] o_M_WDATA,
   output logic [STRB_WIDTH-1:0] o_M_WSTRB,
   input  logic                  i_S_WREADY,
   input  logic                  i_S_BVALID,
   input  logic [1:0]            i_S_BRESP,
   output logic                  o_M_BREADY,
   output logic                  o_M_ARVALID,
   output logic [ADDR_WIDTH-1:0] o_M_ARADDR,
   output logic [2:0]            o_M_ARPROT,
   input  logic                  i_S_ARREADY,
   input  logic                  i_S_RVALID,
   input  logic [DATA_WIDTH-1:0] i_S_RDATA,
   input  logic [1:0]            i_S_RRESP,
   output logic                  o_M_RREADY
);

   state_t                r_state;
   logic                  r_cmdReady;
   logic                  r_awValid;
   logic                  r_wValid;
   logic                  r_bReady;
   logic                  r_arValid;
   logic                  r_rReady;
   logic                  r_awDone;
   logic                  r_wDone;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [STRB_WIDTH-1:0] r_wstrb;
   logic                  r_rspValid;
   logic [DATA_WIDTH-1:0] r_rspRdata;
   logic [1:0]            r_rspResp;
   logic                  r_rspWrite;

   logic w_awHs;
   logic w_wHs;

   assign w_awHs = r_awValid & i_S_AWREADY;
   assign w_wHs  = r_wValid & i_S_WREADY;

   // Every handshake-facing output is a flop; the next state's valids/readies
   // are set on the same edge that moves the FSM.
   always_ff @(posedge i_ACLK or negedge i_ARESETN) begin
      if (!i_ARESETN) begin
         r_state    <= IDLE;
         r_cmdReady <= 1'b0;
         r_awValid  <= 1'b0;
         r_wValid   <= 1'b0;
         r_bReady   <= 1'b0;
         r_arValid  <= 1'b0;
         r_rReady   <= 1'b0;
         r_awDone   <= 1'b0;
         r_wDone    <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_wstrb    <= '0;
         r_rspValid <= 1'b0;
         r_rspRdata <= '0;
         r_rspResp  <= '0;
         r_rspWrite <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (r_cmdReady && i_CMD_VALID) begin
                  r_cmdReady <= 1'b0;
                  r_addr     <= i_CMD_ADDR;
                  r_wdata    <= i_CMD_WDATA;
                  r_wstrb    <= i_CMD_WSTRB;
                  r_rspWrite <= i_CMD_WRITE;
                  r_awDone   <= 1'b0;
                  r_wDone    <= 1'b0;
                  if (i_CMD_WRITE) begin
                     r_awValid <= 1'b1;
                     r_wValid  <= 1'b1;
                     r_state   <= WR_REQ;
                  end else begin
                     r_arValid <= 1'b1;
                     r_state   <= RD_REQ;
                  end
               end else begin
                  r_cmdReady <= 1'b1;
               end
            end
            WR_REQ: begin
               if (w_awHs) begin
                  r_awValid <= 1'b0;
                  r_awDone  <= 1'b1;
               end
               if (w_wHs) begin
                  r_wValid <= 1'b0;
                  r_wDone  <= 1'b1;
               end
               if ((r_awDone || w_awHs) && (r_wDone || w_wHs)) begin
                  r_bReady <= 1'b1;
                  r_state  <= WR_RESP;
               end
            end
            WR_RESP: begin
               if (i_S_BVALID && r_bReady) begin
                  r_bReady   <= 1'b0;
                  r_rspResp  <= i_S_BRESP;
                  r_rspRdata <= '0;
                  r_rspWrite <= 1'b1;
                  r_rspValid <= 1'b1;
                  r_state    <= RESPOND;
               end
            end
            RD_REQ: begin
               if (i_S_ARREADY) begin
                  r_arValid <= 1'b0;
                  r_rReady  <= 1'b1;
                  r_state   <= RD_DATA;
               end
            end
            RD_DATA: begin
               if (i_S_RVALID && r_rReady) begin
                  r_rReady   <= 1'b0;
                  r_rspRdata <= i_S_RDATA;
                  r_rspResp  <= i_S_RRESP;
                  r_rspWrite <= 1'b0;
                  r_rspValid <= 1'b1;
                  r_state    <= RESPOND;
               end
            end
            RESPOND: begin
               if (i_RSP_READY) begin
                  r_rspValid <= 1'b0;
                  r_cmdReady <= 1'b1;
                  r_state    <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_CMD_READY = r_cmdReady;
   assign o_RSP_VALID = r_rspValid;
   assign o_RSP_RDATA = r_rspRdata;
   assign o_RSP_RESP  = r_rspResp;
   assign o_RSP_WRITE = r_rspWrite;
   assign o_M_AWVALID = r_awValid;
   assign o_M_AWADDR  = r_addr;
   assign o_M_AWPROT  = PROT_VALUE;
   assign o_M_WVALID  = r_wValid;
   assign o_M_WDATA   = r_wdata;
   assign o_M_WSTRB   = r_wstrb;
   assign o_M_BREADY  = r_bReady;
   assign o_M_ARVALID = r_arValid;
   assign o_M_ARADDR  = r_addr;
   assign o_M_ARPROT  = PROT_VALUE;
   assign o_M_RREADY  = r_rReady;

endmodule

// File: tb/tb_basic_axi4_lite_master.sv
// Self-checking bench for basic_axi4_lite_master: scripted slave behaviour,
// direct channel checks and a response scoreboard.
module tb_basic_axi4_lite_master;

   logic       clk;
   logic       arstN;
   logic       cmdValid;
   logic       cmdReady;
   logic       cmdWrite;
   logic [1:0] cmdAddr;
   logic [7:0] cmdWdata;
   logic [0:0] cmdWstrb;
   logic       rspValid;
   logic       rspReady;
   logic [7:0] rspRdata;
   logic [1:0] rspResp;
   logic       rspWrite;
   logic       awValid;
   logic [1:0] awAddr;
   logic [2:0] awProt;
   logic       awReady;
   logic       wValid;
   logic [7:0] wData;
   logic [0:0] wStrb;
   logic       wReady;
   logic       bValid;
   logic [1:0] bResp;
   logic       bReady;
   logic       arValid;
   logic [1:0] arAddr;
   logic [2:0] arProt;
   logic       arReady;
   logic       rValid;
   logic [7:0] rData;
   logic [1:0] rResp;
   logic       rReady;

   typedef struct {
      logic [7:0] rdata;
      logic [1:0] resp;
      logic       write;
   } rsp_t;

   rsp_t sb[$];
   int   compared   = 0;
   int   mismatched = 0;

   basic_axi4_lite_master dut (
      .i_ACLK(clk), .i_ARESETN(arstN),
      .i_CMD_VALID(cmdValid), .o_CMD_READY(cmdReady), .i_CMD_WRITE(cmdWrite),
      .i_CMD_ADDR(cmdAddr), .i_CMD_WDATA(cmdWdata), .i_CMD_WSTRB(cmdWstrb),
      .o_RSP_VALID(rspValid), .i_RSP_READY(rspReady), .o_RSP_RDATA(rspRdata),
      .o_RSP_RESP(rspResp), .o_RSP_WRITE(rspWrite),
      .o_M_AWVALID(awValid), .o_M_AWADDR(awAddr), .o_M_AWPROT(awProt), .i_S_AWREADY(awReady),
      .o_M_WVALID(wValid), .o_M_WDATA(wData), .o_M_WSTRB(wStrb), .i_S_WREADY(wReady),
      .i_S_BVALID(bValid), .i_S_BRESP(bResp), .o_M_BREADY(bReady),
      .o_M_ARVALID(arValid), .o_M_ARADDR(arAddr), .o_M_ARPROT(arProt), .i_S_ARREADY(arReady),
      .i_S_RVALID(rValid), .i_S_RDATA(rData), .i_S_RRESP(rResp), .o_M_RREADY(rReady)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      if (obs !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Response handshakes are judged half a cycle before the edge that takes them.
   always @(negedge clk) begin
      if (arstN && rspValid && rspReady) begin
         if (sb.size() == 0) begin
            checkOutput("unexpectedRsp", 32'd1, 32'd0);
         end else begin
            rsp_t e;
            e = sb.pop_front();
            checkOutput("rspRdata", rspRdata, e.rdata);
            checkOutput("rspResp", rspResp, e.resp);
            checkOutput("rspWrite", rspWrite, e.write);
         end
      end
   end

   task automatic applyStimulus(input logic wr, input logic [1:0] addr, input logic [7:0] wd,
                                input logic [7:0] expRdata, input logic [1:0] expResp);
      rsp_t e;
      bit   accepted;
      cmdWrite = wr;
      cmdAddr  = addr;
      cmdWdata = wd;
      cmdWstrb = 1'b1;
      cmdValid = 1'b1;
      e.rdata  = expRdata;
      e.resp   = expResp;
      e.write  = wr;
      sb.push_back(e);
      accepted = 0;
      for (int i = 0; i < 20 && !accepted; i++) begin
         if (cmdReady) accepted = 1;
         tick();
      end
      cmdValid = 1'b0;
      checkOutput("cmdAccept", accepted, 1);
   endtask

   initial begin
      int rspHsIdx;
      int acceptIdx;
      int phase;
      bit overlap;
      bit acc;
      bit hs;
      rsp_t e;

      arstN = 0; cmdValid = 0; cmdWrite = 0; cmdAddr = 0; cmdWdata = 0; cmdWstrb = 0;
      rspReady = 1; awReady = 0; wReady = 0; bValid = 0; bResp = 0;
      arReady = 0; rValid = 0; rData = 0; rResp = 0;

      repeat (3) @(posedge clk);
      #1;
      checkOutput("rstCmdReady", cmdReady, 0);
      checkOutput("rstValids", {awValid, wValid, arValid, rspValid}, 0);
      checkOutput("rstReadies", {bReady, rReady}, 0);
      checkOutput("rstData", {awAddr, wData, wStrb, rspRdata, rspResp}, 0);
      checkOutput("prot", {awProt, arProt}, 0);
      @(negedge clk) arstN = 1;
      tick();
      checkOutput("idleCmdReady", cmdReady, 1);

      $display("[TB] write 0xA5 to addr 2, AW/W ready together");
      awReady = 1; wReady = 1;
      applyStimulus(1, 2'd2, 8'hA5, 8'h00, 2'b00);
      checkOutput("t1AwWValid", {awValid, wValid}, 2'b11);
      checkOutput("t1Payload", {awAddr, wData, wStrb}, {2'd2, 8'hA5, 1'b1});
      checkOutput("t1CmdReadyLow", cmdReady, 0);
      tick();
      checkOutput("t1ValidsDrop", {awValid, wValid}, 0);
      checkOutput("t1BReady", bReady, 1);
      bValid = 1; bResp = 2'b00;
      tick();
      bValid = 0;
      checkOutput("t1RspValid", rspValid, 1);
      checkOutput("t1BReadyDrop", bReady, 0);
      tick();
      checkOutput("t1RspDone", rspValid, 0);
      checkOutput("t1CmdReadyBack", cmdReady, 1);

      $display("[TB] write 0x3C to addr 1, AWREADY 3 cycles before WREADY");
      awReady = 0; wReady = 0;
      applyStimulus(1, 2'd1, 8'h3C, 8'h00, 2'b00);
      awReady = 1;
      tick();
      awReady = 0;
      bValid = 1; bResp = 2'b00;
      for (int i = 0; i < 3; i++) begin
         checkOutput("t2AwDropped", awValid, 0);
         checkOutput("t2WHeld", {wValid, wData}, {1'b1, 8'h3C});
         checkOutput("t2NoEarlyBReady", bReady, 0);
         checkOutput("t2NoEarlyRsp", rspValid, 0);
         tick();
      end
      wReady = 1;
      tick();
      wReady = 0;
      checkOutput("t2WDrop", wValid, 0);
      checkOutput("t2BReady", bReady, 1);
      tick();
      bValid = 0;
      checkOutput("t2RspValid", rspValid, 1);
      tick();

      $display("[TB] read addr 0, ARREADY after 2 cycles");
      applyStimulus(0, 2'd0, 8'h00, 8'h09, 2'b00);
      for (int i = 0; i < 2; i++) begin
         checkOutput("t3ArHeld", {arValid, arAddr}, {1'b1, 2'd0});
         checkOutput("t3NoAw", awValid, 0);
         tick();
      end
      arReady = 1;
      tick();
      arReady = 0;
      checkOutput("t3ArDrop", arValid, 0);
      checkOutput("t3RReady", rReady, 1);
      rValid = 1; rData = 8'h09; rResp = 2'b00;
      tick();
      rValid = 0;
      checkOutput("t3RspValid", rspValid, 1);
      checkOutput("t3RReadyDrop", rReady, 0);
      tick();

      $display("[TB] read addr 3 with SLVERR, consumer stalls 4 cycles");
      rspReady = 0; arReady = 1;
      applyStimulus(0, 2'd3, 8'h00, 8'h77, 2'b10);
      checkOutput("t4ArAddr", {arValid, arAddr}, {1'b1, 2'd3});
      tick();
      arReady = 0;
      rValid = 1; rData = 8'h77; rResp = 2'b10;
      tick();
      rValid = 0;
      for (int i = 0; i < 4; i++) begin
         checkOutput("t4RspHeld", {rspValid, rspResp, rspRdata}, {1'b1, 2'b10, 8'h77});
         checkOutput("t4CmdReadyLow", cmdReady, 0);
         tick();
      end
      rspReady = 1;
      checkOutput("t4CmdReadyAtHs", cmdReady, 0);
      tick();
      checkOutput("t4RspDone", rspValid, 0);
      checkOutput("t4CmdReadyAfterHs", cmdReady, 1);

      $display("[TB] reset pulse during RD_DATA");
      arReady = 1;
      applyStimulus(0, 2'd2, 8'h00, 8'h00, 2'b00);
      tick();
      arReady = 0;
      checkOutput("t5InRdData", rReady, 1);
      #2 arstN = 0;
      #1;
      checkOutput("t5RstOutputs", {arValid, rReady, rspValid, cmdReady}, 0);
      void'(sb.pop_back());
      @(negedge clk) arstN = 1;
      tick();
      checkOutput("t5CmdReady", cmdReady, 1);
      for (int i = 0; i < 3; i++) begin
         checkOutput("t5NoStaleRsp", rspValid, 0);
         tick();
      end

      $display("[TB] back-to-back write then read with CMD_VALID held");
      awReady = 1; wReady = 1; bValid = 1; bResp = 2'b00;
      arReady = 1; rValid = 1; rData = 8'h5A; rResp = 2'b00;
      cmdWrite = 1; cmdAddr = 2'd0; cmdWdata = 8'h81; cmdWstrb = 1'b1; cmdValid = 1;
      e.rdata = 8'h00; e.resp = 2'b00; e.write = 1'b1;
      sb.push_back(e);
      phase = 0; rspHsIdx = -1; acceptIdx = -1; overlap = 0;
      for (int c = 0; c < 40; c++) begin
         if (awValid && arValid) overlap = 1;
         acc = cmdReady && cmdValid;
         hs  = rspValid && rspReady;
         if (hs && phase == 1 && rspHsIdx < 0) rspHsIdx = c;
         if (acc && phase == 1) acceptIdx = c;
         tick();
         if (acc) begin
            if (phase == 0) begin
               cmdWrite = 0; cmdAddr = 2'd1;
               e.rdata = 8'h5A; e.resp = 2'b00; e.write = 1'b0;
               sb.push_back(e);
               phase = 1;
            end else if (phase == 1) begin
               cmdValid = 0;
               phase = 2;
            end
         end
      end
      awReady = 0; wReady = 0; bValid = 0; arReady = 0; rValid = 0; cmdValid = 0;
      checkOutput("t6NoOverlap", overlap, 0);
      checkOutput("t6SecondAccepted", phase, 2);
      checkOutput("t6AcceptAfterHs", acceptIdx, rspHsIdx + 1);

      tick();
      checkOutput("queueEmpty", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
